// File: rtl/m216a_pkg.sv
// Shared widths for the MASH 1-1-1 fractional-N modulator.
package m216a_pkg;

    localparam int unsigned IW = 4;   // integer input / output width
    localparam int unsigned FW = 16;  // fractional word and accumulator width
    localparam int unsigned YW = 4;   // signed combiner width, holds -3..+4

    // Zero-extend a carry bit into the signed combiner width.
    function automatic logic signed [YW-1:0] carry_ext(input logic b);
        return {{(YW-1){1'b0}}, b};
    endfunction

endpackage

// File: rtl/m216a_acc_stage.sv
// One first-order accumulator stage: FW-bit register, combinational sum and carry-out.
module m216a_acc_stage
    import m216a_pkg::*;
#(
    parameter int unsigned W = FW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W-1:0] acc_q;

    // Accumulator wraps modulo 2^W; the carry is the only overflow path.
    always_comb begin
        {carry, sum} = {1'b0, acc_q} + {1'b0, in};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= sum;
        end
    end

endmodule

// File: rtl/m216a_top_module.sv
// MASH 1-1-1 delta-sigma modulator producing a dithered integer divide value.
module m216a_top_module
    import m216a_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] in_i,
    input  logic [FW-1:0] in_f,
    output logic [IW-1:0] out
);

    logic [FW-1:0] s1, s2, s3;
    logic          c1, c2, c3;
    logic          c2_d_q, c3_d_q, c3_dd_q;
    logic signed [YW-1:0] y;
    logic [IW-1:0] out_d;

    m216a_acc_stage #(.W(FW)) u_acc1 (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in_f),
        .sum   (s1),
        .carry (c1)
    );

    m216a_acc_stage #(.W(FW)) u_acc2 (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (s1),
        .sum   (s2),
        .carry (c2)
    );

    m216a_acc_stage #(.W(FW)) u_acc3 (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (s2),
        .sum   (s3),
        .carry (c3)
    );

    // Noise-cancel: c1 + (1-z^-1)c2 + (1-z^-1)^2 c3.
    always_comb begin
        y = carry_ext(c1) + carry_ext(c2) - carry_ext(c2_d_q) + carry_ext(c3)
            - (carry_ext(c3_d_q) <<< 1) + carry_ext(c3_dd_q);
        out_d = in_i + IW'($unsigned(y));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c2_d_q  <= 1'b0;
            c3_d_q  <= 1'b0;
            c3_dd_q <= 1'b0;
            out     <= '0;
        end else begin
            c2_d_q  <= c2;
            c3_d_q  <= c3;
            c3_dd_q <= c3_d_q;
            out     <= out_d;
        end
    end

    logic unused_s3;
    assign unused_s3 = ^s3;

endmodule

// File: tb/tb_m216a_top_module.sv
// Self-checking bench for m216a_top_module: vector table, reference model and scoreboard.
module tb_m216a_top_module;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_i;
    logic [15:0] in_f;
    logic [3:0]  out;

    int checks;
    int errors;
    int sb[$];
    int last_out;

    // Reference model state
    int m_acc1, m_acc2, m_acc3;
    int m_c2d, m_c3d, m_c3dd;

    typedef struct {
        logic r;
        int   ii;
        int   ff;
        int   exp;
    } vec_t;

    vec_t vecs[12];

    m216a_top_module dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in_i  (in_i),
        .in_f  (in_f),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input int lo_v, input int hi_v,
                               input int lo, input int hi);
        checks++;
        if (lo_v < lo || hi_v > hi) begin
            errors++;
            $display("FAIL %s: got min %0d max %0d required %0d..%0d", name, lo_v, hi_v, lo, hi);
        end
    endtask

    task automatic model_step(input logic r, input int ii, input int ff, output int exp);
        int t1, t2, t3, c1, c2, c3, s1, s2, s3, y;
        if (!r) begin
            m_acc1 = 0; m_acc2 = 0; m_acc3 = 0;
            m_c2d = 0; m_c3d = 0; m_c3dd = 0;
            exp = 0;
        end else begin
            t1 = m_acc1 + ff;  c1 = t1 >> 16; s1 = t1 & 32'hFFFF;
            t2 = m_acc2 + s1;  c2 = t2 >> 16; s2 = t2 & 32'hFFFF;
            t3 = m_acc3 + s2;  c3 = t3 >> 16; s3 = t3 & 32'hFFFF;
            y = c1 + c2 - m_c2d + c3 - 2 * m_c3d + m_c3dd;
            exp = (ii + y) & 15;
            m_acc1 = s1; m_acc2 = s2; m_acc3 = s3;
            m_c3dd = m_c3d; m_c3d = c3; m_c2d = c2;
        end
    endtask

    // Drive one cycle; expected value is the override when >= 0, else the model's.
    task automatic step(input string name, input logic r, input int ii, input int ff,
                        input int override, input bit chk);
        int exp;
        int e;
        @(negedge clk);
        rst_n = r;
        in_i  = 4'(ii);
        in_f  = 16'(ff);
        model_step(r, ii, ff, exp);
        if (chk) sb.push_back(override >= 0 ? override : exp);
        @(posedge clk);
        #1;
        last_out = int'(out);
        if (chk) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL %s: got empty scoreboard expected entry", name);
            end else begin
                e = sb.pop_front();
                check(name, last_out, e);
            end
        end
    endtask

    initial begin
        int sum, mn, mx, win;
        longint lsum, target, diff;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        in_i = 4'd8;
        in_f = 16'd32000;

        // Reset hold
        for (int i = 0; i < 5; i++) step("reset_hold", 1'b0, 8, 32000, 0, 1'b1);
        check("acc1_reset", int'(dut.u_acc1.acc_q), 0);
        check("acc2_reset", int'(dut.u_acc2.acc_q), 0);
        check("acc3_reset", int'(dut.u_acc3.acc_q), 0);

        // Vector table: integer-only then the exact 5.5 sequence
        vecs[0]  = '{1'b0, 8, 0, 0};
        vecs[1]  = '{1'b1, 8, 0, 8};
        vecs[2]  = '{1'b1, 8, 0, 8};
        vecs[3]  = '{1'b1, 8, 0, 8};
        vecs[4]  = '{1'b0, 5, 32768, 0};
        vecs[5]  = '{1'b1, 5, 32768, 5};
        vecs[6]  = '{1'b1, 5, 32768, 7};
        vecs[7]  = '{1'b1, 5, 32768, 4};
        vecs[8]  = '{1'b1, 5, 32768, 6};
        vecs[9]  = '{1'b0, 3, 100, 0};
        vecs[10] = '{1'b1, 3, 0, 3};
        vecs[11] = '{1'b1, 12, 0, 12};
        for (int i = 0; i < 12; i++) step("vector", vecs[i].r, vecs[i].ii, vecs[i].ff,
                                         vecs[i].exp, 1'b1);

        // Integer only, 128 cycles
        step("int_reset", 1'b0, 8, 0, 0, 1'b1);
        for (int i = 0; i < 128; i++) step("int_only", 1'b1, 8, 0, 8, 1'b1);

        // Half fraction: 4-cycle window means and range
        step("half_reset", 1'b0, 5, 32768, 0, 1'b1);
        mn = 99; mx = -99;
        for (int w = 0; w < 16; w++) begin
            win = 0;
            for (int i = 0; i < 4; i++) begin
                step("half_seq", 1'b1, 5, 32768, -1, 1'b1);
                win += last_out;
                if (last_out < mn) mn = last_out;
                if (last_out > mx) mx = last_out;
            end
            check("half_window_sum", win, 22);
        end
        check_range("half_range", mn, mx, 2, 9);

        // Mean accuracy over a full modulus period
        step("mean_reset", 1'b0, 8, 32000, 0, 1'b1);
        sum = 0; mn = 99; mx = -99;
        for (int i = 0; i < 65536; i++) begin
            step("mean_seq", 1'b1, 8, 32000, -1, i < 256);
            sum += last_out;
            if (last_out < mn) mn = last_out;
            if (last_out > mx) mx = last_out;
            if (i == 127) begin
                checks++;
                if (sum * 1000 < 128 * 8438 || sum * 1000 > 128 * 8538) begin
                    errors++;
                    $display("FAIL mean_128: got sum %0d required avg 8.488+-0.05", sum);
                end
            end
        end
        check("mean_sum_65536", sum, 8 * 65536 + 32000);
        check_range("mean_range", mn, mx, 5, 12);

        // Max fraction, low then high integer
        step("maxf_reset", 1'b0, 3, 65535, 0, 1'b1);
        lsum = 0; mn = 99; mx = -99;
        for (int i = 0; i < 4096; i++) begin
            step("maxf_seq", 1'b1, 3, 65535, -1, i < 256);
            lsum += last_out;
            if (last_out < mn) mn = last_out;
            if (last_out > mx) mx = last_out;
        end
        check_range("maxf_range_low", mn, mx, 0, 7);
        target = 64'd3 * 4096 * 65536 + 64'd4096 * 65535;
        diff = lsum * 65536 - target;
        if (diff < 0) diff = -diff;
        checks++;
        if (diff > 3 * 65536) begin
            errors++;
            $display("FAIL maxf_mean: got sum %0d required about %0d", lsum, target / 65536);
        end
        mn = 99; mx = -99;
        for (int i = 0; i < 1024; i++) begin
            step("maxf_hi_seq", 1'b1, 11, 65535, -1, i < 64);
            if (last_out < mn) mn = last_out;
            if (last_out > mx) mx = last_out;
        end
        check_range("maxf_range_high", mn, mx, 8, 15);

        // Mid-run input change without clearing accumulators
        step("mid_reset", 1'b0, 8, 32000, 0, 1'b1);
        for (int i = 0; i < 50; i++) step("mid_pre", 1'b1, 8, 32000, -1, 1'b1);
        for (int i = 0; i < 40; i++) step("mid_post", 1'b1, 8, 16384, -1, 1'b1);
        check("mid_acc1", int'(dut.u_acc1.acc_q), m_acc1);

        // One-cycle reset pulse, then restart identical to a fresh run
        step("pulse_low", 1'b0, 8, 32000, 0, 1'b1);
        for (int i = 0; i < 64; i++) step("pulse_after", 1'b1, 8, 32000, -1, 1'b1);

        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
